// File: rtl/complex_alu_pkg.sv
// Shared op codes and compare-fill helpers for the complex ALU pipeline.
package complex_alu_pkg;

   localparam int unsigned OP_W   = 4;
   localparam int unsigned FILL_W = 64;

   localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
   localparam logic [OP_W-1:0] OP_MUL  = 4'd2;
   localparam logic [OP_W-1:0] OP_REAL = 4'd4;
   localparam logic [OP_W-1:0] OP_IMAG = 4'd5;
   localparam logic [OP_W-1:0] OP_CONJ = 4'd6;
   localparam logic [OP_W-1:0] OP_MOVE = 4'd7;
   localparam logic [OP_W-1:0] OP_LESS = 4'd9;
   localparam logic [OP_W-1:0] OP_EQ   = 4'd10;
   localparam logic [OP_W-1:0] OP_LE   = 4'd11;
   localparam logic [OP_W-1:0] OP_GT   = 4'd12;
   localparam logic [OP_W-1:0] OP_NE   = 4'd13;
   localparam logic [OP_W-1:0] OP_GE   = 4'd14;
   localparam logic [OP_W-1:0] OP_MEM  = 4'd15;

   localparam logic [FILL_W-1:0] FILL_TRUE  = '1;
   localparam logic [FILL_W-1:0] FILL_FALSE = '0;

   // Callers narrow the fill to their component width with a size cast.
   function automatic logic [FILL_W-1:0] fill_bool(input logic b);
      return b ? FILL_TRUE : FILL_FALSE;
   endfunction

   function automatic logic is_compare(input logic [OP_W-1:0] op);
      case (op)
         OP_LESS, OP_EQ, OP_LE, OP_GT, OP_NE, OP_GE: return 1'b1;
         default:                                    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/complex_alu_pipe_if.sv
// Operand/result handshake bundle between register-read, the ALU and writeback.
interface complex_alu_pipe_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a_re;
   logic [WIDTH-1:0] a_im;
   logic [WIDTH-1:0] b_re;
   logic [WIDTH-1:0] b_im;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_re;
   logic [WIDTH-1:0] out_im;
   logic             out_ovf;
   logic             comp_flag;

   modport master (
      output in_valid, op, a_re, a_im, b_re, b_im, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_ovf, comp_flag
   );

   modport slave (
      input  in_valid, op, a_re, a_im, b_re, b_im, out_ready,
      output in_ready, out_valid, out_re, out_im, out_ovf, comp_flag
   );
endinterface

// File: rtl/complex_alu_pipe_clamp.sv
// Signed narrowing from IN_W to OUT_W bits: saturate or wrap, flagging out-of-range.
module cplx_clamp #(
   parameter int unsigned IN_W     = 17,
   parameter int unsigned OUT_W    = 8,
   parameter bit          SATURATE = 1'b0
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout_c,
   output logic                    ovf_c
);
   localparam int unsigned HEAD_W = IN_W - OUT_W + 1;
   localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

   logic [HEAD_W-1:0] head;

   // In range only when every bit above the result sign matches it.
   assign head  = din[IN_W-1:OUT_W-1];
   assign ovf_c = (head != '0) && (head != '1);

   always_comb begin
      dout_c = din[OUT_W-1:0];
      if (SATURATE && ovf_c) begin
         dout_c = din[IN_W-1] ? MIN_NEG : MAX_POS;
      end
   end
endmodule

// File: rtl/complex_alu_pipe.sv
// Two-stage complex ALU: stage 1 captures operands, products and sums; stage 2 combines, scales and clamps.
module complex_alu_pipe
   import complex_alu_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned FRAC     = 0,
   parameter bit          SATURATE = 1'b0
) (
   input logic               clk,
   input logic               rst_n,
   complex_alu_pipe_if.slave bus
);
   localparam int unsigned AW = WIDTH + 1;
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned SW = 2 * WIDTH + 1;

   typedef struct packed {
      logic [WIDTH-1:0] re;
      logic [WIDTH-1:0] im;
   } cplx_t;

   cplx_t                 a_in, b_in;
   logic signed [PW-1:0]  p_rr, p_ii, p_ri, p_ir;
   logic signed [AW-1:0]  lin_re, lin_im;
   logic [PW-1:0]         mem_sum;
   logic                  s1_adv, s2_adv;

   logic                  s1_valid;
   logic [OP_W-1:0]       s1_op;
   cplx_t                 s1_a, s1_b;
   logic signed [AW-1:0]  s1_lin_re, s1_lin_im;
   logic signed [SW-1:0]  s1_mul_re, s1_mul_im;
   logic [PW-1:0]         s1_mem;

   logic signed [SW-1:0]    wide_re, wide_im;
   logic                    is_cmp, cmp_true;
   logic signed [WIDTH-1:0] clamp_re, clamp_im;
   logic                    ovf_re, ovf_im;

   logic             out_valid_q, out_ovf_q, out_is_cmp_q, out_cmp_q, comp_flag_q;
   logic [WIDTH-1:0] out_re_q, out_im_q;

   assign s2_adv       = !out_valid_q || bus.out_ready;
   assign s1_adv       = !s1_valid || s2_adv;
   assign bus.in_ready = s1_adv;

   assign a_in    = {bus.a_re, bus.a_im};
   assign b_in    = {bus.b_re, bus.b_im};
   assign p_rr    = PW'($signed(a_in.re)) * PW'($signed(b_in.re));
   assign p_ii    = PW'($signed(a_in.im)) * PW'($signed(b_in.im));
   assign p_ri    = PW'($signed(a_in.re)) * PW'($signed(b_in.im));
   assign p_ir    = PW'($signed(a_in.im)) * PW'($signed(b_in.re));
   assign mem_sum = a_in + b_in;

   always_comb begin
      lin_re = AW'($signed(a_in.re)) + AW'($signed(b_in.re));
      lin_im = AW'($signed(a_in.im)) + AW'($signed(b_in.im));
      if (bus.op == OP_SUB) begin
         lin_re = AW'($signed(a_in.re)) - AW'($signed(b_in.re));
         lin_im = AW'($signed(a_in.im)) - AW'($signed(b_in.im));
      end
   end

   // Stage 1: operands, op, and the wide sums/products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_op     <= '0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_lin_re <= '0;
         s1_lin_im <= '0;
         s1_mul_re <= '0;
         s1_mul_im <= '0;
         s1_mem    <= '0;
      end else if (s1_adv) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_op     <= bus.op;
            s1_a      <= a_in;
            s1_b      <= b_in;
            s1_lin_re <= lin_re;
            s1_lin_im <= lin_im;
            s1_mul_re <= SW'(p_rr) - SW'(p_ii);
            s1_mul_im <= SW'(p_ri) + SW'(p_ir);
            s1_mem    <= mem_sum;
         end
      end
   end

   // Every op is expressed as a sign-extended wide value so one clamp decides range and overflow.
   always_comb begin
      wide_re  = '0;
      wide_im  = '0;
      cmp_true = 1'b0;
      is_cmp   = is_compare(s1_op);
      case (s1_op)
         OP_ADD, OP_SUB: begin
            wide_re = SW'(s1_lin_re);
            wide_im = SW'(s1_lin_im);
         end
         OP_MUL: begin
            wide_re = s1_mul_re >>> FRAC;
            wide_im = s1_mul_im >>> FRAC;
         end
         OP_REAL: wide_re = SW'($signed(s1_a.re));
         OP_IMAG: wide_re = SW'($signed(s1_a.im));
         OP_CONJ: begin
            wide_re = SW'($signed(s1_a.re));
            wide_im = -SW'($signed(s1_a.im));
         end
         OP_MOVE: begin
            wide_re = SW'($signed(s1_a.re));
            wide_im = SW'($signed(s1_a.im));
         end
         OP_LESS: cmp_true = $signed(s1_a.re) <  $signed(s1_b.re);
         OP_LE:   cmp_true = $signed(s1_a.re) <= $signed(s1_b.re);
         OP_GT:   cmp_true = $signed(s1_a.re) >  $signed(s1_b.re);
         OP_GE:   cmp_true = $signed(s1_a.re) >= $signed(s1_b.re);
         OP_EQ:   cmp_true = (s1_a == s1_b);
         OP_NE:   cmp_true = (s1_a != s1_b);
         OP_MEM: begin
            wide_re = SW'($signed(s1_mem[PW-1:WIDTH]));
            wide_im = SW'($signed(s1_mem[WIDTH-1:0]));
         end
         default: ;
      endcase
      if (is_cmp) begin
         wide_re = SW'($signed(WIDTH'(fill_bool(cmp_true))));
         wide_im = wide_re;
      end
   end

   cplx_clamp #(.IN_W(SW), .OUT_W(WIDTH), .SATURATE(SATURATE)) u_clamp_re (
      .din(wide_re), .dout_c(clamp_re), .ovf_c(ovf_re)
   );

   cplx_clamp #(.IN_W(SW), .OUT_W(WIDTH), .SATURATE(SATURATE)) u_clamp_im (
      .din(wide_im), .dout_c(clamp_im), .ovf_c(ovf_im)
   );

   // Stage 2: result registers, held while the consumer stalls; comp_flag loads on a compare handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_re_q     <= '0;
         out_im_q     <= '0;
         out_ovf_q    <= 1'b0;
         out_is_cmp_q <= 1'b0;
         out_cmp_q    <= 1'b0;
         comp_flag_q  <= 1'b0;
      end else begin
         if (s2_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
               out_re_q     <= clamp_re;
               out_im_q     <= clamp_im;
               out_ovf_q    <= ovf_re || ovf_im;
               out_is_cmp_q <= is_cmp;
               out_cmp_q    <= cmp_true;
            end
         end
         if (out_valid_q && bus.out_ready && out_is_cmp_q) begin
            comp_flag_q <= out_cmp_q;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_re    = out_re_q;
   assign bus.out_im    = out_im_q;
   assign bus.out_ovf   = out_ovf_q;
   assign bus.comp_flag = comp_flag_q;
endmodule

// File: tb/tb_complex_alu_pipe.sv
// Scoreboard bench: a saturating FRAC=0 pipe and a wrapping FRAC=2 pipe driven with identical stimulus.
module tb_complex_alu_pipe;
   import complex_alu_pkg::*;

   typedef struct packed {
      logic [7:0] re;
      logic [7:0] im;
      logic       ovf;
      logic       cmp;
      logic       cmp_val;
   } exp_t;

   logic       clk, rst_n;
   logic       in_valid, out_ready;
   logic [3:0] op;
   logic [7:0] a_re, a_im, b_re, b_im;
   int         errors = 0;
   int         checks = 0;
   exp_t       q_s[$], q_w[$];
   logic       flag_s = 1'b0, flag_w = 1'b0;
   logic       hold_s = 1'b0, hold_w = 1'b0;
   logic [16:0] last_s = '0, last_w = '0;

   complex_alu_pipe_if #(.WIDTH(8)) if_s ();
   complex_alu_pipe_if #(.WIDTH(8)) if_w ();

   complex_alu_pipe #(.WIDTH(8), .FRAC(0), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst_n(rst_n), .bus(if_s)
   );
   complex_alu_pipe #(.WIDTH(8), .FRAC(2), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .bus(if_w)
   );

   assign if_s.in_valid = in_valid;  assign if_w.in_valid = in_valid;
   assign if_s.out_ready = out_ready; assign if_w.out_ready = out_ready;
   assign if_s.op = op;     assign if_w.op = op;
   assign if_s.a_re = a_re; assign if_w.a_re = a_re;
   assign if_s.a_im = a_im; assign if_w.a_im = a_im;
   assign if_s.b_re = b_re; assign if_w.b_re = b_re;
   assign if_s.b_im = b_im; assign if_w.b_im = b_im;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] fit(input int v, input bit sat);
      logic [31:0] u;
      logic        ov;
      u  = v;
      ov = (v > 127) || (v < -128);
      if (ov && sat) return {1'b1, (v < 0) ? 8'h80 : 8'h7F};
      return {ov, u[7:0]};
   endfunction

   // Reference behaviour written from the op table with plain integer arithmetic.
   function automatic exp_t model(input logic [3:0] o, input logic [7:0] ar, ai, br, bi,
                                  input bit sat, input int frac);
      exp_t e;
      int xr, xi, yr, yi;
      logic [8:0] fr, fi;
      logic [15:0] m;
      xr = $signed(ar); xi = $signed(ai); yr = $signed(br); yi = $signed(bi);
      e = '0;
      fr = '0; fi = '0;
      case (o)
         OP_ADD:  begin fr = fit(xr + yr, sat); fi = fit(xi + yi, sat); end
         OP_SUB:  begin fr = fit(xr - yr, sat); fi = fit(xi - yi, sat); end
         OP_MUL:  begin
            fr = fit((xr * yr - xi * yi) >>> frac, sat);
            fi = fit((xr * yi + xi * yr) >>> frac, sat);
         end
         OP_REAL: fr = {1'b0, ar};
         OP_IMAG: fr = {1'b0, ai};
         OP_MOVE: begin fr = {1'b0, ar}; fi = {1'b0, ai}; end
         OP_CONJ: begin fr = {1'b0, ar}; fi = fit(-xi, sat); end
         OP_MEM:  begin m = {ar, ai} + {br, bi}; fr = {1'b0, m[15:8]}; fi = {1'b0, m[7:0]}; end
         OP_LESS, OP_EQ, OP_LE, OP_GT, OP_NE, OP_GE: begin
            e.cmp = 1'b1;
            case (o)
               OP_LESS: e.cmp_val = xr < yr;
               OP_LE:   e.cmp_val = xr <= yr;
               OP_GT:   e.cmp_val = xr > yr;
               OP_GE:   e.cmp_val = xr >= yr;
               OP_EQ:   e.cmp_val = (xr == yr) && (xi == yi);
               default: e.cmp_val = (xr != yr) || (xi != yi);
            endcase
            fr = {1'b0, {8{e.cmp_val}}};
            fi = fr;
         end
         default: ;
      endcase
      e.re  = fr[7:0];
      e.im  = fi[7:0];
      e.ovf = fr[8] | fi[8];
      return e;
   endfunction

   // Saturating instance: push on input handshake, pop on output handshake, watch stalls and comp_flag.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q_s.delete(); flag_s = 1'b0; hold_s = 1'b0;
      end else begin
         if (hold_s) begin
            check("s_hold_valid", if_s.out_valid, 1);
            check("s_hold_data", {if_s.out_re, if_s.out_im, if_s.out_ovf}, last_s);
         end
         check("s_comp_flag", if_s.comp_flag, flag_s);
         if (if_s.out_valid && out_ready) begin
            check("s_queue_nonempty", q_s.size() != 0, 1);
            if (q_s.size() != 0) begin
               e = q_s.pop_front();
               check("s_out", {if_s.out_re, if_s.out_im, if_s.out_ovf}, {e.re, e.im, e.ovf});
               if (e.cmp) flag_s = e.cmp_val;
            end
         end
         hold_s = if_s.out_valid && !out_ready;
         last_s = {if_s.out_re, if_s.out_im, if_s.out_ovf};
         if (in_valid && if_s.in_ready) q_s.push_back(model(op, a_re, a_im, b_re, b_im, 1'b1, 0));
      end
   end

   // Wrapping FRAC=2 instance, same scheme.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q_w.delete(); flag_w = 1'b0; hold_w = 1'b0;
      end else begin
         if (hold_w) begin
            check("w_hold_valid", if_w.out_valid, 1);
            check("w_hold_data", {if_w.out_re, if_w.out_im, if_w.out_ovf}, last_w);
         end
         check("w_comp_flag", if_w.comp_flag, flag_w);
         if (if_w.out_valid && out_ready) begin
            check("w_queue_nonempty", q_w.size() != 0, 1);
            if (q_w.size() != 0) begin
               e = q_w.pop_front();
               check("w_out", {if_w.out_re, if_w.out_im, if_w.out_ovf}, {e.re, e.im, e.ovf});
               if (e.cmp) flag_w = e.cmp_val;
            end
         end
         hold_w = if_w.out_valid && !out_ready;
         last_w = {if_w.out_re, if_w.out_im, if_w.out_ovf};
         if (in_valid && if_w.in_ready) q_w.push_back(model(op, a_re, a_im, b_re, b_im, 1'b0, 2));
      end
   end

   task automatic set_in(input logic [3:0] o, input logic [7:0] ar, ai, br, bi);
      op = o; a_re = ar; a_im = ai; b_re = br; b_im = bi;
   endtask

   task automatic send(input logic [3:0] o, input logic [7:0] ar, ai, br, bi);
      logic hs;
      int   n;
      hs = 1'b0;
      n  = 0;
      set_in(o, ar, ai, br, bi);
      in_valid = 1'b1;
      while (!hs && n < 50) begin
         @(negedge clk);
         hs = if_s.in_ready;
         @(posedge clk); #1;
         n++;
      end
      check("send_handshake", hs, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q_s.size() != 0 || q_w.size() != 0) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_in_time", n < 50, 1);
   endtask

   initial begin
      int idx, acc;
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      set_in(OP_ADD, 8'd0, 8'd0, 8'd0, 8'd0);
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", if_s.out_valid, 0);
      check("rst_out_data", {if_s.out_re, if_s.out_im, if_s.out_ovf}, 0);
      check("rst_comp_flag", if_s.comp_flag, 0);
      check("rst_in_ready", if_s.in_ready, 1);
      check("rst_w_out_valid", if_w.out_valid, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;

      // Overflowing ADD: saturates on one instance, wraps on the other.
      send(OP_ADD, 8'd100, -8'sd100, 8'd50, -8'sd50);
      drain();

      // MUL latency: nothing after one edge, result after the second.
      send(OP_MUL, 8'd3, 8'd4, 8'd2, -8'sd1);
      @(negedge clk);
      check("mul_lat_early", if_s.out_valid, 0);
      @(negedge clk);
      check("mul_lat_valid", if_s.out_valid, 1);
      check("mul_sat_val", {if_s.out_re, if_s.out_im, if_s.out_ovf}, {8'd10, 8'd5, 1'b0});
      check("mul_frac2_val", {if_w.out_re, if_w.out_im, if_w.out_ovf}, {8'd2, 8'd1, 1'b0});
      drain();
      send(OP_MUL, 8'd8, 8'd0, 8'd8, 8'd0);
      send(OP_MUL, -8'sd3, 8'd0, 8'd1, 8'd0);
      send(OP_MUL, 8'd127, 8'd127, 8'd127, -8'sd128);
      drain();

      // LESS sets comp_flag one cycle after its output handshake; illegal ops leave it alone.
      check("flag_init", if_s.comp_flag, 0);
      send(OP_LESS, 8'hFF, 8'h00, 8'h01, 8'h00);
      @(negedge clk);
      @(negedge clk);
      check("less_out", {if_s.out_re, if_s.out_im, if_s.out_ovf}, {8'hFF, 8'hFF, 1'b0});
      check("flag_before_update", if_s.comp_flag, 0);
      @(negedge clk);
      check("flag_after_update", if_s.comp_flag, 1);
      send(4'd3, 8'd1, 8'd2, 8'd3, 8'd4);
      send(4'd8, 8'd5, 8'd6, 8'd7, 8'd8);
      drain();
      check("flag_after_illegal", if_s.comp_flag, 1);

      // Remaining ops streamed back to back.
      send(OP_SUB, -8'sd100, 8'd100, 8'd100, -8'sd100);
      send(OP_REAL, 8'd7, -8'sd3, 8'd1, 8'd1);
      send(OP_IMAG, 8'd7, -8'sd3, 8'd1, 8'd1);
      send(OP_MOVE, 8'd7, -8'sd3, 8'd1, 8'd1);
      send(OP_CONJ, 8'd5, 8'h80, 8'd0, 8'd0);
      send(OP_CONJ, 8'd5, -8'sd3, 8'd0, 8'd0);
      send(OP_MEM, 8'h12, 8'hF0, 8'h00, 8'h20);
      send(OP_EQ, 8'd9, 8'd9, 8'd9, 8'd9);
      send(OP_NE, 8'd9, 8'd9, 8'd9, 8'd8);
      send(OP_LE, 8'd9, 8'd0, 8'd9, 8'd3);
      send(OP_GT, -8'sd5, 8'd0, 8'd4, 8'd0);
      send(OP_GE, 8'd4, 8'd0, -8'sd5, 8'd0);
      drain();

      // Back-pressure: four ADDs against a stalled consumer, then release.
      out_ready = 1'b0;
      idx = 0;
      acc = 0;
      set_in(OP_ADD, 8'd0, 8'd1, 8'd3, 8'd4);
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (if_s.in_ready) begin acc++; idx++; end
         @(posedge clk); #1;
         if (idx < 4) set_in(OP_ADD, 8'(idx * 10), 8'(idx + 1), 8'd3, 8'd4);
      end
      check("bp_accepted", acc, 2);
      check("bp_in_ready_low", if_s.in_ready, 0);
      check("bp_w_in_ready_low", if_w.in_ready, 0);
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("bp_stream_valid", if_s.out_valid, 1);
         if (in_valid && if_s.in_ready) idx++;
         @(posedge clk); #1;
         if (idx < 4) set_in(OP_ADD, 8'(idx * 10), 8'(idx + 1), 8'd3, 8'd4);
         else in_valid = 1'b0;
      end
      check("bp_all_sent", idx, 4);
      in_valid = 1'b0;
      drain();

      // Asynchronous reset with two ops in flight and comp_flag set.
      send(OP_EQ, 8'd5, 8'd5, 8'd5, 8'd5);
      drain();
      check("pre_rst_flag", if_s.comp_flag, 1);
      out_ready = 1'b0;
      send(OP_ADD, 8'd1, 8'd1, 8'd1, 8'd1);
      send(OP_ADD, 8'd2, 8'd2, 8'd2, 8'd2);
      check("pre_rst_valid", if_s.out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", if_s.out_valid, 0);
      check("async_rst_flag", if_s.comp_flag, 0);
      check("async_rst_w_valid", if_w.out_valid, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("no_stale_out", if_s.out_valid | if_w.out_valid, 0);
      end
      check("queues_empty", q_s.size() + q_w.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
